// File: rtl/spike_encoder.sv
// Temporal spike encoder: accepts a pixel frame over valid/ready and plays it out as
// per-pixel spike times across one time period, with a one-deep pending buffer.
`ifndef SE_NUM_SPIKES
`define SE_NUM_SPIKES 4
`endif
`ifndef SE_TIME_PERIOD
`define SE_TIME_PERIOD 8
`endif

module spike_encoder #(
  parameter int NUM_SPIKES  = `SE_NUM_SPIKES,
  parameter int TIME_PERIOD = `SE_TIME_PERIOD,
  parameter int PIXEL_BITS  = 8,
  parameter int THRESHOLD   = 16,
  localparam int SB         = $clog2(TIME_PERIOD)
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_SPIKES*PIXEL_BITS-1:0] in_pixels,
  input  logic                             in_training,
  output logic [NUM_SPIKES-1:0][SB:0]      spike_times,
  output logic [SB:0]                      time_val,
  output logic                             training,
  output logic                             frame_start,
  output logic                             frame_done,
  output logic                             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SB:0]           NO_SPIKE = {1'b1, {SB{1'b0}}};
  localparam logic [SB:0]           LAST_T   = (SB+1)'(TIME_PERIOD - 1);
  localparam logic [SB:0]           PENULT_T = (SB+1)'(TIME_PERIOD - 2);
  localparam logic [PIXEL_BITS-1:0] THR      = PIXEL_BITS'(THRESHOLD);

  state_t                        state;
  logic                          pend_valid;
  logic                          pend_training;
  logic [NUM_SPIKES-1:0][SB:0]   pend_times;
  logic [NUM_SPIKES-1:0][SB:0]   enc_times;
  logic                          accept;

  // Brighter pixels map to earlier times: invert, then keep the top SB bits.
  function automatic logic [SB:0] encode(input logic [PIXEL_BITS-1:0] pix);
    logic [PIXEL_BITS-1:0] inv;
    inv = (~pix) >> (PIXEL_BITS - SB);
    if (pix < THR) return NO_SPIKE;
    return {1'b0, inv[SB-1:0]};
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    enc_times = '0;
    for (int i = 0; i < NUM_SPIKES; i++)
      enc_times[i] = encode(in_pixels[i*PIXEL_BITS +: PIXEL_BITS]);
  end

  assign in_ready = !pend_valid;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every read below sees pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      pend_training <= 1'b0;
      pend_times    <= '{default: NO_SPIKE};
      spike_times   <= '{default: NO_SPIKE};
      time_val      <= '0;
      training      <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Accept and transfer are mutually exclusive: accept needs pend_valid==0.
      if (accept) begin
        pend_times    <= enc_times;
        pend_training <= in_training;
        pend_valid    <= 1'b1;
      end

      case (state)
        IDLE: begin
          time_val    <= '0;
          frame_done  <= 1'b0;
          if (pend_valid) begin
            spike_times <= pend_times;
            training    <= pend_training;
            pend_valid  <= 1'b0;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end else begin
            spike_times <= '{default: NO_SPIKE};
            training    <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
          end
        end

        RUN: begin
          if (time_val == LAST_T) begin
            time_val   <= '0;
            frame_done <= 1'b0;
            if (pend_valid) begin
              spike_times <= pend_times;
              training    <= pend_training;
              pend_valid  <= 1'b0;
              frame_start <= 1'b1;
            end else begin
              spike_times <= '{default: NO_SPIKE};
              training    <= 1'b0;
              frame_start <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            time_val    <= time_val + 1'b1;
            frame_start <= 1'b0;
            frame_done  <= (time_val == PENULT_T);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: idle/reset values, encoding, back-to-back frames,
// continuous streaming and mid-frame reset.
module tb_spike_encoder;

  localparam int NS = 4;
  localparam int TP = 8;
  localparam int PB = 8;

  logic              clk;
  logic              rst_l;
  logic              in_valid;
  logic              in_ready;
  logic [NS*PB-1:0]  in_pixels;
  logic              in_training;
  logic [NS-1:0][3:0] spike_times;
  logic [3:0]        time_val;
  logic              training;
  logic              frame_start;
  logic              frame_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  spike_encoder #(
    .NUM_SPIKES (NS),
    .TIME_PERIOD(TP),
    .PIXEL_BITS (PB),
    .THRESHOLD  (16)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixels  (in_pixels),
    .in_training(in_training),
    .spike_times(spike_times),
    .time_val   (time_val),
    .training   (training),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, in_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_tv"}, time_val, 4'd0);
    check({tag, "_times"}, spike_times, 16'h8888);
    check({tag, "_train"}, training, 1'b0);
    check({tag, "_fs"}, frame_start, 1'b0);
    check({tag, "_fd"}, frame_done, 1'b0);
  endtask

  // Packed pixel and expected-time vectors; entry 0 is the least significant.
  localparam logic [31:0] PIX_A   = {8'd15, 8'd16, 8'd128, 8'd255};
  localparam logic [15:0] TIMES_A = 16'h8730;
  localparam logic [31:0] PIX_B   = {8'd0, 8'd50, 8'd100, 8'd200};
  localparam logic [15:0] TIMES_B = 16'h8641;

  initial begin
    int hs;
    int starts;
    int bubbles;
    bit started;
    bit drained;

    rst_l       = 1'b0;
    in_valid    = 1'b0;
    in_pixels   = '0;
    in_training = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    rst_l = 1'b1;
    step();
    check_idle("post_rst");

    // Frame A from IDLE, frame B offered at time_val==2
    in_pixels   = PIX_A;
    in_training = 1'b1;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    check("a_ready_drop", in_ready, 1'b0);
    check("a_busy_pre", busy, 1'b0);
    step();
    for (int k = 0; k < TP; k++) begin
      if (k == 3) in_valid = 1'b0;
      check($sformatf("a_tv%0d", k), time_val, k);
      check($sformatf("a_fs%0d", k), frame_start, k == 0);
      check($sformatf("a_fd%0d", k), frame_done, k == TP - 1);
      check($sformatf("a_times%0d", k), spike_times, TIMES_A);
      check($sformatf("a_train%0d", k), training, 1'b1);
      check($sformatf("a_busy%0d", k), busy, 1'b1);
      if (k >= 3) check($sformatf("a_ready%0d", k), in_ready, 1'b0);
      if (k == 2) begin
        in_pixels   = PIX_B;
        in_training = 1'b0;
        in_valid    = 1'b1;
      end
      if (k < TP - 1) step();
    end
    in_pixels   = '1;
    in_training = 1'b1;
    step();

    // Frame B back-to-back
    check("b_tv0", time_val, 4'd0);
    check("b_fs", frame_start, 1'b1);
    check("b_busy", busy, 1'b1);
    check("b_times", spike_times, TIMES_B);
    check("b_train", training, 1'b0);
    check("b_ready", in_ready, 1'b1);
    for (int k = 1; k < TP; k++) begin
      step();
      check($sformatf("b_tv%0d", k), time_val, k);
      check($sformatf("b_fd%0d", k), frame_done, k == TP - 1);
    end
    step();
    check_idle("end_idle");

    // Continuous in_valid: one accept every TP cycles, no bubble cycles
    in_pixels   = '1;
    in_training = 1'b1;
    in_valid    = 1'b1;
    hs = 0; starts = 0; bubbles = 0; started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_valid && in_ready) hs++;
      step();
      if (frame_start) starts++;
      if (frame_start) check("s_times", spike_times, 16'h0000);
      if (started && !busy) bubbles++;
      if (busy) started = 1'b1;
    end
    in_valid = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      step();
      if (frame_start) starts++;
      if (!busy && in_ready) drained = 1'b1;
    end
    check("s_drained", drained, 1'b1);
    check("s_handshakes", hs, 6);
    check("s_starts", starts, hs);
    check("s_bubbles", bubbles, 0);

    // Mid-frame reset with a pending frame
    in_pixels   = PIX_A;
    in_training = 1'b1;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_pixels = PIX_B;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("r_tv4", time_val, 4'd4);
    check("r_pending", in_ready, 1'b0);
    rst_l = 1'b0;
    #1;
    check_idle("r_async");
    @(negedge clk);
    rst_l = 1'b1;
    starts = 0;
    bubbles = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_start) starts++;
      if (busy) bubbles++;
    end
    check("r_no_start", starts, 0);
    check("r_no_busy", bubbles, 0);
    check_idle("r_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Upstream feeder for the spiking layer.
- Accepts one frame of pixel intensities over a valid/ready handshake and temporally encodes each pixel as a spike time: brighter pixels spike earlier; pixels below a threshold do not spike.
- Generates the per-period time_val sweep and the training qualifier consumed by the layer.
- Has a one-entry pending buffer, so consecutive frames run back-to-back with no gap cycles.

Parameters:
- NUM_SPIKES, default `num_spikes: number of inputs/pixels per frame.
- TIME_PERIOD, default `time_period: cycles per frame; must be a power of two, >=2.
- PIXEL_BITS, default 8: pixel intensity width; must be >= SB, where SB = $clog2(TIME_PERIOD).
- THRESHOLD, default 16: pixels strictly below this value produce no spike.

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- in_valid  in  1  frame offered
- in_ready  out  1  frame can be accepted (= !pend_valid)
- in_pixels  in  NUM_SPIKES*PIXEL_BITS  pixel i at [i*PIXEL_BITS +: PIXEL_BITS]
- in_training  in  1  training flag captured with the frame
- spike_times  out  [NUM_SPIKES-1:0][SB:0]  per-input spike time; MSB=1 means no spike
- time_val  out  SB+1  current time step within the period
- training  out  1  training flag of the active frame; 0 when idle
- frame_start  out  1  one-cycle pulse, high while time_val==0 of an active frame
- frame_done  out  1  one-cycle pulse, high while time_val==TIME_PERIOD-1 of an active frame
- busy  out  1  a frame is active (state RUN)

Behaviour:
- Reset is asynchronous, active-low (rst_l); clock is clk. Reset values:
  - state=IDLE, pend_valid=0, so in_ready=1
  - time_val=0; every spike_times entry = {1'b1, SB'b0}
  - training=0, frame_start=0, frame_done=0, busy=0
  - Reset mid-frame aborts immediately; the pending frame is discarded.
- Encoding (applied at acceptance, per pixel p):
  - p < THRESHOLD: {1'b1, SB'b0} (no spike)
  - else: {1'b0, (~p) >> (PIXEL_BITS-SB)}, truncated to SB bits
  - Result: p = 2^PIXEL_BITS-1 encodes to time 0; p = THRESHOLD encodes late.
- Handshake: accept when in_valid && in_ready at a clk edge.
  - Encoded times and in_training go to the pend registers; pend_valid is set.
  - in_ready is registered-derived and drops the cycle after acceptance.
  - in_pixels and in_training may change freely after acceptance.
- FSM, IDLE:
  - time_val=0, spike_times all no-spike, training=0.
  - If pend_valid: next edge transfers pend to active, clears pend_valid, sets time_val=0, enters RUN, asserts frame_start.
- FSM, RUN:
  - time_val increments by 1 each cycle.
  - spike_times and training are held stable for the whole period.
  - In the cycle where time_val==TIME_PERIOD-1, frame_done=1. At the following edge:
    - pend_valid=1: transfer pend, time_val=0, stay in RUN, frame_start=1 (back-to-back, no bubble).
    - else: go IDLE, time_val=0, outputs return to idle values.
- Acceptance during RUN is allowed whenever in_ready=1.
  - Acceptance on the same edge as a transfer cannot occur, because in_ready=0 while pend_valid=1.
- Latency: handshake at edge N (IDLE) -> time_val=0 with new spike_times after edge N+1.
- time_val never exceeds TIME_PERIOD-1; there is no wrap within a frame.
- frame_start and frame_done are both high only if TIME_PERIOD==1; this is disallowed.
- All outputs are registered.

Test Plan:
1. Reset, then check idle outputs: in_ready=1, busy=0, time_val=0, spike_times[i]=4'b1000 (TIME_PERIOD=8, PIXEL_BITS=8, THRESHOLD=16, NUM_SPIKES=4).
2. Offer pixels {255,128,16,15} with in_training=1 in IDLE -> two edges later spike_times={0,3,7,4'b1000}, training=1, frame_start=1, time_val=0. time_val then counts 0..7, and frame_done is high only at 7.
3. Offer frame B during frame A's RUN (at time_val=2) -> in_ready low until transfer. After A's time_val=7, the next cycle has time_val=0 with B's times, frame_start=1 and busy held 1.
4. No pending frame at end of period -> after time_val=7, busy=0, training=0, spike_times all no-spike, in_ready=1.
5. Hold in_valid high continuously -> a frame is accepted every 8 cycles with no bubble cycles. Counts match the number of handshakes.
6. Assert rst_l low at time_val=4 with a frame pending -> all outputs return immediately to reset values. After release there is no spurious frame_start and the pending frame is lost.
